denise_pixel_color_pipe: RTL



---
 rtl/denise_pix_pkg.sv | 24 ++
 rtl/denise_ham_modify.sv | 50 +++++
 rtl/denise_pixel_color_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/denise_pix_pkg.sv
// Shared types for the Denise pixel colour pipe: pixel class, HAM flavour and
// the colour-table word unpack.
package denise_pix_pkg;

  typedef enum logic [2:0] {
    PIX_BORDER,
    PIX_LOOKUP,
    PIX_EHB,
    PIX_MOD_R,
    PIX_MOD_G,
    PIX_MOD_B
  } pix_class_t;

  typedef enum logic {
    HAM_MODE6 = 1'b0,
    HAM_MODE8 = 1'b1
  } ham_mode_t;

  // Table word holds the high nibbles of R,G,B in [23:12] and the low nibbles in [11:0].
  function automatic logic [23:0] ct_unpack(input logic [23:0] q);
    return {q[23:20], q[11:8], q[19:16], q[7:4], q[15:12], q[3:0]};
  endfunction

endpackage

// File: rtl/denise_ham_modify.sv
// Combinational colour resolve: lookup, Extra-Half-Brite or hold-and-modify.
// HAM8 datapath exists only when DENISE_HAM8_EN is defined; otherwise all HAM is HAM6.
module denise_ham_modify
  import denise_pix_pkg::*;
(
  input  pix_class_t  cls,
  input  ham_mode_t   mode,
  input  logic [5:0]  val,
  input  logic [23:0] hold,
  input  logic [23:0] word,
  output logic [23:0] rgb
);

  logic [7:0] mod_r;
  logic [7:0] mod_g;
  logic [7:0] mod_b;

`ifdef DENISE_HAM8_EN
  // HAM8 replaces the top six bits and keeps the held channel's two LSBs.
  always_comb begin
    if (mode == HAM_MODE8) begin
      mod_r = {val, hold[17:16]};
      mod_g = {val, hold[9:8]};
      mod_b = {val, hold[1:0]};
    end else begin
      mod_r = {val[3:0], val[3:0]};
      mod_g = {val[3:0], val[3:0]};
      mod_b = {val[3:0], val[3:0]};
    end
  end
`else
  logic unused_ham8;
  assign unused_ham8 = ^{mode, val[5:4]};
  assign mod_r = {val[3:0], val[3:0]};
  assign mod_g = {val[3:0], val[3:0]};
  assign mod_b = {val[3:0], val[3:0]};
`endif

  always_comb begin
    rgb = word;
    case (cls)
      PIX_EHB:   rgb = {1'b0, word[23:17], 1'b0, word[15:9], 1'b0, word[7:1]};
      PIX_MOD_R: rgb = {mod_r, hold[15:0]};
      PIX_MOD_G: rgb = {hold[23:16], mod_g, hold[7:0]};
      PIX_MOD_B: rgb = {hold[23:8], mod_b};
      default:   rgb = word;
    endcase
  end

endmodule

// File: rtl/denise_pixel_color_pipe.sv
// Two-stage Denise pixel colour pipe: classify + table address, then resolve to RGB.
// Latency 2 clocks pix_en->rgb_valid, full throughput. HAM8 gated by DENISE_HAM8_EN.
module denise_pixel_color_pipe
  import denise_pix_pkg::*;
#(
  parameter logic [23:0] RESET_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        window,
  input  logic [7:0]  pix_idx,
  input  logic        ham_en,
  input  logic        ham8,
  input  logic        ehb_en,
  input  logic        killehb,
  output logic [7:0]  ct_rdaddress,
  input  logic [23:0] ct_q,
  output logic [23:0] rgb_out,
  output logic        rgb_valid
);

  pix_class_t  cls_c;
  ham_mode_t   mode_c;
  logic [5:0]  val_c;
  logic [1:0]  ctrl;

  logic        s1_vld;
  pix_class_t  s1_cls;
  ham_mode_t   s1_mode;
  logic [5:0]  s1_val;

  logic [23:0] hold;
  logic [23:0] rgb_next;

`ifndef DENISE_HAM8_EN
  logic unused_ham8;
  assign unused_ham8 = ham8;
`endif

  always_comb begin
    cls_c        = PIX_LOOKUP;
    mode_c       = HAM_MODE6;
    val_c        = 6'd0;
    ctrl         = 2'b00;
    ct_rdaddress = pix_idx;
    if (!window) begin
      cls_c        = PIX_BORDER;
      ct_rdaddress = 8'h00;
    end else if (ham_en) begin
      ctrl  = pix_idx[5:4];
      val_c = {2'b00, pix_idx[3:0]};
`ifdef DENISE_HAM8_EN
      if (ham8) begin
        mode_c = HAM_MODE8;
        ctrl   = pix_idx[1:0];
        val_c  = pix_idx[7:2];
      end
`endif
      // Both HAM flavours look up the zero-extended value field.
      case (ctrl)
        2'b00: begin
          cls_c        = PIX_LOOKUP;
          ct_rdaddress = {2'b00, val_c};
        end
        2'b01:   cls_c = PIX_MOD_B;
        2'b10:   cls_c = PIX_MOD_R;
        default: cls_c = PIX_MOD_G;
      endcase
    end else if (ehb_en && !killehb && pix_idx[5]) begin
      cls_c        = PIX_EHB;
      ct_rdaddress = {3'b000, pix_idx[4:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_cls  <= PIX_BORDER;
      s1_mode <= HAM_MODE6;
      s1_val  <= 6'd0;
    end else begin
      s1_vld  <= pix_en;
      s1_cls  <= cls_c;
      s1_mode <= mode_c;
      s1_val  <= val_c;
    end
  end

  denise_ham_modify u_ham_modify (
    .cls  (s1_cls),
    .mode (s1_mode),
    .val  (s1_val),
    .hold (hold),
    .word (ct_unpack(ct_q)),
    .rgb  (rgb_next)
  );

  // Every emitted pixel, border included, becomes the new hold colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out   <= RESET_RGB;
      hold      <= RESET_RGB;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= s1_vld;
      if (s1_vld) begin
        rgb_out <= rgb_next;
        hold    <= rgb_next;
      end
    end
  end

endmodule
